// File: rtl/shreg_io_pkg.sv
// Shared definitions for the shift-register I/O chain controllers.
//
// Contents:
//   sipo_state_t  - phase FSM encoding for the SIPO chain reader
//   frame_cycles  - clk cycles in one complete SIPO frame: load, WIDTH
//                   low/high bit pairs, and the trailing gap

package shreg_io_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StLow,
        StHigh,
        StGap
    } sipo_state_t;

    // One load phase, two phases per bit, one gap phase.
    function automatic int unsigned frame_cycles(input int unsigned width,
                                                 input int unsigned clk_div);
        return (2 * width + 2) * clk_div;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
//
// Ports:
//   clk     in   destination clock
//   aclr_n  in   asynchronous active-low reset (both flops clear to 0)
//   d       in   asynchronous input
//   q       out  synchronized output, two clk cycles of latency

module bit_sync (
    input  logic clk,
    input  logic aclr_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sipo_always.sv
// Free-running reader for a daisy-chain of SN74HC165 parallel-in shift
// registers. Each frame loads the chain, clocks WIDTH bits in MSB first,
// publishes the raw frame, and maintains a debounced copy of the inputs.
//
// Parameters:
//   WIDTH     total chain bits (8 per device)
//   CLK_DIV   clk cycles per sclk half-period and per load/gap phase (>= 4)
//   DEBOUNCE  consecutive identical frames needed to update data (>= 1)
//
// Ports:
//   clk      in   system clock
//   aclr_n   in   asynchronous active-low reset
//   sclr     in   synchronous clear, same effect as reset
//   sclk     out  chain shift clock, registered
//   load_n   out  chain SH/LD_n, registered, active-low
//   sdi      in   chain serial data (QH of the last device), asynchronous
//   raw      out  last complete unfiltered frame
//   data     out  debounced inputs
//   frame    out  one-cycle pulse when raw updates
//   changed  out  one-cycle pulse when data takes a new value

module sipo_always
    import shreg_io_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CLK_DIV  = 10,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             sclr,
    output logic             sclk,
    output logic             load_n,
    input  logic             sdi,
    output logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] data,
    output logic             frame,
    output logic             changed
);

    localparam int unsigned PhW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam int unsigned StbW = $clog2(DEBOUNCE + 1);

    localparam logic [PhW-1:0]  PhaseLast = PhW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitsAll   = BitW'(WIDTH);
    localparam logic [StbW-1:0] StableMax = StbW'(DEBOUNCE);

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic sdi_s;

    bit_sync u_sdi_sync (
        .clk    (clk),
        .aclr_n (aclr_n),
        .d      (sdi),
        .q      (sdi_s)
    );

    // ------------------------------------------------------------------
    // Phase sequencer
    // ------------------------------------------------------------------
    sipo_state_t     state_q, state_d;
    logic [PhW-1:0]  phase_q, phase_d;
    logic [BitW-1:0] bit_q, bit_d;
    // Low after reset/sclr so the first edge afterwards enters LOAD at
    // phase 0 while the outputs still show the idle values.
    logic            run_q;

    logic            phase_last;
    logic            shift_en;
    logic            frame_end;

    assign phase_last = (phase_q == PhaseLast);
    assign shift_en   = run_q && (state_q == StLow) && phase_last;
    assign frame_end  = run_q && (state_q == StGap) && phase_last;

    // State register.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= StLoad;
            phase_q <= '0;
            bit_q   <= '0;
            run_q   <= 1'b0;
        end else if (sclr) begin
            state_q <= StLoad;
            phase_q <= '0;
            bit_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            run_q   <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PhW'(1);
        bit_d   = bit_q;
        if (!run_q) begin
            state_d = StLoad;
            phase_d = '0;
            bit_d   = '0;
        end else if (phase_last) begin
            phase_d = '0;
            unique case (state_q)
                StLoad: begin
                    state_d = StLow;
                    bit_d   = '0;
                end
                StLow: begin
                    state_d = StHigh;
                    bit_d   = bit_q + BitW'(1);
                end
                StHigh: begin
                    state_d = (bit_q == BitsAll) ? StGap : StLow;
                end
                StGap: begin
                    state_d = StLoad;
                end
                default: begin
                    state_d = StLoad;
                end
            endcase
        end
    end

    // Output logic: decoded from the next state and registered, so the
    // chain pins change only on clk edges and track the phase exactly.
    logic sclk_d, load_n_d;
    logic sclk_q, load_n_q;

    always_comb begin
        sclk_d   = 1'b0;
        load_n_d = 1'b1;
        if (run_q || !sclr) begin
            sclk_d   = (state_d == StHigh);
            load_n_d = (state_d != StLoad);
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sclk_q   <= 1'b0;
            load_n_q <= 1'b1;
        end else if (sclr) begin
            sclk_q   <= 1'b0;
            load_n_q <= 1'b1;
        end else begin
            sclk_q   <= sclk_d;
            load_n_q <= load_n_d;
        end
    end

    // ------------------------------------------------------------------
    // Shift register and debounce
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] raw_q;
    logic [WIDTH-1:0] data_q;
    logic [StbW-1:0]  stable_q;
    logic [StbW-1:0]  stable_n;
    logic             frame_q;
    logic             changed_q;
    logic             upd_data;

    // Run length of identical frames, saturating at DEBOUNCE; a frame that
    // differs from the previous one starts a new run of length one.
    always_comb begin
        if (shreg_q == raw_q) begin
            stable_n = (stable_q >= StableMax) ? StableMax : stable_q + StbW'(1);
        end else begin
            stable_n = StbW'(1);
        end
    end

    assign upd_data = frame_end && (stable_n >= StableMax) && (shreg_q != data_q);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            shreg_q   <= '0;
            raw_q     <= '0;
            data_q    <= '0;
            stable_q  <= '0;
            frame_q   <= 1'b0;
            changed_q <= 1'b0;
        end else if (sclr) begin
            shreg_q   <= '0;
            raw_q     <= '0;
            data_q    <= '0;
            stable_q  <= '0;
            frame_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            frame_q   <= frame_end;
            changed_q <= upd_data;
            if (shift_en) begin
                shreg_q <= {shreg_q[WIDTH-2:0], sdi_s};
            end
            if (frame_end) begin
                raw_q    <= shreg_q;
                stable_q <= stable_n;
            end
            if (upd_data) begin
                data_q <= shreg_q;
            end
        end
    end

    assign sclk    = sclk_q;
    assign load_n  = load_n_q;
    assign raw     = raw_q;
    assign data    = data_q;
    assign frame   = frame_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sipo_always.sv
module tb_sipo_always;
    import shreg_io_pkg::*;

    localparam int W     = 16;
    localparam int CD    = 10;
    localparam int DEB   = 3;
    localparam int FRAME = frame_cycles(W, CD);

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          sclr = 1'b0;
    logic          sclk, load_n, sdi;
    logic [W-1:0]  raw, data;
    logic          frame, changed;
    logic [W-1:0]  pin = '0;
    logic [W-1:0]  chain = '0;

    always #5 clk = ~clk;

    sipo_always #(
        .WIDTH    (W),
        .CLK_DIV  (CD),
        .DEBOUNCE (DEB)
    ) dut (
        .clk     (clk),
        .aclr_n  (aclr_n),
        .sclr    (sclr),
        .sclk    (sclk),
        .load_n  (load_n),
        .sdi     (sdi),
        .raw     (raw),
        .data    (data),
        .frame   (frame),
        .changed (changed)
    );

    int n_err = 0;
    int n_checks = 0;
    int n_changed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Two chained SN74HC165s seen as one 16-bit register: level load while
    // SH/LD_n is low, shift toward sdi on each sclk rise.
    assign sdi = chain[W-1];
    initial begin
        logic sclk_prev;
        sclk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!load_n) chain = pin;
            else if (sclk && !sclk_prev) chain = {chain[W-2:0], 1'b0};
            sclk_prev = sclk;
        end
    end

    // Behavioural model: the frame schedule from cycle arithmetic, raw as the
    // word loaded at the start of each frame, data from the frame history.
    int           cyc = -1;
    logic [W-1:0] m_raw = '0, m_data = '0, latched = '0;
    logic         m_frame = 1'b0, m_changed = 1'b0;
    logic [W-1:0] hist[$];

    initial begin
        forever begin
            @(posedge clk);
            if (changed) n_changed++;
            m_frame   = 1'b0;
            m_changed = 1'b0;
            if (!aclr_n || sclr) begin
                cyc    = -1;
                m_raw  = '0;
                m_data = '0;
                hist.delete();
            end else begin
                cyc++;
                if (cyc > 0 && cyc % FRAME == 0) begin
                    logic all_same;
                    hist.push_back(latched);
                    m_frame = 1'b1;
                    m_raw   = latched;
                    if (hist.size() >= DEB) begin
                        all_same = 1'b1;
                        for (int i = 0; i < DEB; i++)
                            if (hist[hist.size() - 1 - i] != latched) all_same = 1'b0;
                        if (all_same && latched != m_data) begin
                            m_data    = latched;
                            m_changed = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            logic e_sclk, e_load_n;
            int   p;
            @(negedge clk);
            if (!aclr_n) begin
                cyc       = -1;
                m_raw     = '0;
                m_data    = '0;
                m_frame   = 1'b0;
                m_changed = 1'b0;
                hist.delete();
            end
            e_sclk   = 1'b0;
            e_load_n = 1'b1;
            if (cyc >= 0) begin
                p        = cyc % FRAME;
                if (p == CD - 1) latched = pin;
                e_load_n = (p >= CD);
                e_sclk   = (p >= CD) && (p < FRAME - CD) && (((p - CD) % (2 * CD)) >= CD);
            end
            chk("sclk", 32'(sclk), 32'(e_sclk));
            chk("load_n", 32'(load_n), 32'(e_load_n));
            chk("frame", 32'(frame), 32'(m_frame));
            chk("changed", 32'(changed), 32'(m_changed));
            chk("raw", 32'(raw), 32'(m_raw));
            chk("data", 32'(data), 32'(m_data));
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 2 * FRAME);
        chk("frame_seen", 32'(frame), 32'd1);
    endtask

    initial begin
        // Reset and first frame with all inputs low.
        repeat (3) @(negedge clk);
        aclr_n = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == 0)        chk("load_low_c0", 32'(load_n), 32'd0);
            if (k == CD - 1)   chk("load_low_c9", 32'(load_n), 32'd0);
            if (k == CD)       chk("load_rel_c10", 32'(load_n), 32'd1);
            if (k == 2*CD - 1) chk("sclk_low_c19", 32'(sclk), 32'd0);
            if (k == 2*CD)     chk("sclk_rise_c20", 32'(sclk), 32'd1);
            if (k == FRAME) begin
                chk("first_frame_c340", 32'(frame), 32'd1);
                chk("first_raw", 32'(raw), 32'h0);
                chk("first_no_changed", 32'(changed), 32'd0);
            end
        end

        // Debounce.
        pin = 16'h1234;
        wait_frame();
        chk("deb_raw_f1", 32'(raw), 32'h1234);
        chk("deb_data_f1", 32'(data), 32'h0);
        wait_frame();
        wait_frame();
        chk("deb_data_f3", 32'(data), 32'h1234);
        chk("deb_changed_f3", 32'(changed), 32'd1);
        wait_frame();
        wait_frame();
        chk("deb_single_pulse", 32'(n_changed), 32'd1);

        // One-frame glitch.
        pin = 16'h5678;
        wait_frame();
        chk("glitch_raw", 32'(raw), 32'h5678);
        chk("glitch_data", 32'(data), 32'h1234);
        pin = 16'h1234;
        repeat (3) wait_frame();
        chk("glitch_raw_back", 32'(raw), 32'h1234);
        chk("glitch_no_pulse", 32'(n_changed), 32'd1);

        // Bit order.
        pin = 16'h8001;
        repeat (3) wait_frame();
        chk("order_raw", 32'(raw), 32'h8001);
        chk("order_data", 32'(data), 32'h8001);

        // Random input sequence, held for a random number of frames.
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 2) == 0) pin = 16'($urandom);
            wait_frame();
        end

        // sclr during the high phase of bit 7.
        wait_frame();
        repeat (4*CD + 14*CD + 5) @(negedge clk);
        chk("sclr_pre_sclk", 32'(sclk), 32'd1);
        sclr = 1'b1;
        @(negedge clk);
        chk("sclr_sclk", 32'(sclk), 32'd0);
        chk("sclr_load_n", 32'(load_n), 32'd1);
        chk("sclr_data", 32'(data), 32'h0);
        chk("sclr_raw", 32'(raw), 32'h0);
        sclr = 1'b0;
        @(negedge clk);
        chk("sclr_restart_load", 32'(load_n), 32'd0);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame && n < 2 * FRAME);
            chk("sclr_next_frame_cycles", 32'(n), 32'(FRAME));
        end

        // Asynchronous reset while sclk is high.
        begin
            int n = 0;
            do begin
                @(posedge clk);
                #2;
                n++;
            end while (!sclk && n < FRAME);
            chk("async_pre_sclk", 32'(sclk), 32'd1);
        end
        aclr_n = 1'b0;
        #1;
        chk("async_sclk", 32'(sclk), 32'd0);
        chk("async_load_n", 32'(load_n), 32'd1);
        chk("async_raw", 32'(raw), 32'h0);
        chk("async_data", 32'(data), 32'h0);
        chk("async_frame", 32'(frame), 32'd0);
        chk("async_changed", 32'(changed), 32'd0);
        repeat (3) @(negedge clk);
        aclr_n = 1'b1;
        pin = 16'hA5C3;
        repeat (3) wait_frame();
        chk("post_reset_data", 32'(data), 32'hA5C3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
